// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter that multiplexes NumReq requesters onto one single-port SRAM.
// After reset it clears every word to zero before granting anything.
module sram_rr_arbiter #(
    parameter int NumReq    = 4,
    parameter int NumWords  = 1024,
    parameter int DataWidth = 64,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                sram_req_o,
    output logic                                sram_we_o,
    output logic [AddrWidth-1:0]                sram_addr_o,
    output logic [DataWidth-1:0]                sram_wdata_o,
    output logic [BeWidth-1:0]                  sram_be_o,
    input  logic [DataWidth-1:0]                sram_rdata_i,
    output logic                                init_done_o
);

    localparam int IdxWidth = $clog2(NumReq);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e                              state_q, state_d;
    logic [AddrWidth-1:0]                cnt_q, cnt_d;
    logic [IdxWidth-1:0]                 rr_q, rr_d;
    logic [IdxWidth-1:0]                 gnt_idx;
    logic                                gnt_any;
    logic                                active;
    logic                                rd_fire;
    logic [Latency-1:0]                  vld_q;
    logic [Latency-1:0][IdxWidth-1:0]    idx_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, independent of order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rr_q    <= '0;
            vld_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            vld_q[0] <= rd_fire;
            for (int i = 1; i < Latency; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // NOTE: the index pipeline has no reset; it is only ever read when the
    // matching valid bit is set, so clearing it would be wasted logic.
    always_ff @(posedge clk_i) begin
        idx_q[0] <= gnt_idx;
        for (int i = 1; i < Latency; i++) idx_q[i] <= idx_q[i-1];
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            if (cnt_q == LastAddr) state_d = RUN;
            else                   cnt_d   = cnt_q + 1'b1;
        end
    end

    // Rotating priority: first asserted request at or after rr_q wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NumReq;
            if (!gnt_any && req_i[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IdxWidth'(idx);
            end
        end
    end

    assign active  = rst_ni && (state_q == RUN) && gnt_any;
    assign rd_fire = active && !we_i[gnt_idx];

    always_comb begin
        rr_d = rr_q;
        if (active) rr_d = (int'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        gnt_o        = '0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (state_q)
            INIT: begin
                sram_req_o  = rst_ni;
                sram_we_o   = 1'b1;
                sram_addr_o = cnt_q;
                sram_be_o   = '1;
            end
            RUN: begin
                if (active) begin
                    gnt_o[gnt_idx] = 1'b1;
                    sram_req_o     = 1'b1;
                    sram_we_o      = we_i[gnt_idx];
                    sram_addr_o    = addr_i[gnt_idx];
                    sram_wdata_o   = wdata_i[gnt_idx];
                    sram_be_o      = be_i[gnt_idx];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rvalid_o = '0;
        if (vld_q[Latency-1]) rvalid_o[idx_q[Latency-1]] = 1'b1;
    end

    assign rdata_o     = sram_rdata_i;
    assign init_done_o = (state_q == RUN);

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter NumWords, default 1024, SRAM depth in words.
REQ-003 SHALL have parameter DataWidth, default 64, word width in bits.
REQ-004 SHALL have parameter ByteWidth, default 8, bits per byte-enable lane.
REQ-005 SHALL have parameter Latency, default 1, SRAM read latency in cycles (1..3).
REQ-006 SHALL derive AddrWidth = clog2(NumWords), minimum 1, and BeWidth = ceil(DataWidth/ByteWidth); neither is overridable.
REQ-007 SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  clock; rst_ni  in  1  reset.
REQ-008 SHALL provide, per requester: req_i  in  NumReq  request; we_i  in  NumReq  write enable; addr_i  in  NumReq x AddrWidth  address; wdata_i  in  NumReq x DataWidth  write data; be_i  in  NumReq x BeWidth  byte enables.
REQ-009 SHALL provide the requester-side outputs: gnt_o  out  NumReq  grant; rvalid_o  out  NumReq  read data valid; rdata_o  out  DataWidth  read data, shared by all requesters.
REQ-010 SHALL provide the single SRAM port: sram_req_o  out  1; sram_we_o  out  1; sram_addr_o  out  AddrWidth; sram_wdata_o  out  DataWidth; sram_be_o  out  BeWidth; sram_rdata_i  in  DataWidth.
REQ-011 SHALL provide init_done_o  out  1, high once the memory clear has completed.

Function
REQ-012 SHALL implement the FSM states INIT and RUN; the state after reset is INIT.
REQ-013 In INIT: SHALL assert sram_req_o=1, sram_we_o=1, sram_wdata_o=0 and sram_be_o=all-ones every cycle, with sram_addr_o driven from a counter that starts at 0 and increments by 1 per cycle.
REQ-014 SHALL move from INIT to RUN in the cycle after the counter reaches NumWords-1; the counter SHALL NOT wrap.
REQ-015 SHALL hold gnt_o=0 throughout INIT; init_done_o SHALL be 1 if and only if the state is RUN.
REQ-016 In RUN: SHALL grant at most one requester per cycle, round-robin; the search SHALL start at a pointer rr_q and take the first asserted req_i at index rr_q, rr_q+1, ... (mod NumReq).
REQ-017 Grant SHALL be combinational in the request cycle; the granted requester's we/addr/wdata/be SHALL be driven onto the SRAM port in that same cycle, with sram_req_o=1.
REQ-018 When no request is pending: SHALL drive sram_req_o=0 and leave rr_q unchanged.
REQ-019 On a grant to index k: SHALL set rr_q to (k+1) mod NumReq, wrapping from NumReq-1 to 0.
REQ-020 Requesters SHALL hold req_i and the request fields stable until granted; the arbiter SHALL NOT record ungranted requests, so a request that drops is lost.
REQ-021 For a granted read: SHALL pipeline the requester index Latency cycles; rvalid_o[k] SHALL be 1 exactly Latency cycles after the grant, and rdata_o SHALL equal sram_rdata_i in that cycle.
REQ-022 Granted writes SHALL produce no rvalid_o pulse.
REQ-023 SHALL sustain back-to-back reads from different requesters at one per cycle, with responses delivered in grant order.
REQ-024 SHALL keep at most one bit of rvalid_o high in any cycle; rdata_o SHALL be don't-care while rvalid_o=0.

Reset
REQ-025 When rst_ni=0 at a clock edge, SHALL set: state=INIT, counter=0, rr_q=0, rvalid pipeline cleared, gnt_o=0, rvalid_o=0, init_done_o=0.
REQ-026 A reset in the middle of INIT or RUN SHALL restart the clear at address 0; read responses in flight SHALL be discarded.
REQ-027 While rst_ni=0: SHALL drive sram_req_o=0.

Verification (NumReq=4, NumWords=16, DataWidth=32, ByteWidth=8, Latency=1)
REQ-028 Release reset -> 16 consecutive writes to addr 0..15 with wdata=0 and be=4'hF; init_done_o=1 from cycle 17 onward; gnt_o=0 throughout the clear.
REQ-029 req_i=4'hF held continuously after init -> gnt_o sequence 0001, 0010, 0100, 1000, 0001.
REQ-030 req0 writes addr 5, data 32'hDEADBEEF, be 4'hF; then req2 reads addr 5 -> rvalid_o=4'b0100 one cycle after the grant, rdata_o=32'hDEADBEEF.
REQ-031 After the REQ-030 write, req1 writes addr 5, data 32'h11223344, be 4'b0011; then a read of addr 5 -> rdata_o=32'hDEAD3344.
REQ-032 rst_ni pulsed low while the INIT counter=7 -> the clear restarts at addr 0, and init_done_o rises only after 16 further writes.
REQ-033 With rr_q=2 and only req_i[1] asserted -> gnt_o=0010 in the same cycle, and rr_q becomes 2.
